// File: rtl/timer_interrupt_controller.sv
// -----------------------------------------------------------------------------
// timer_interrupt_controller
//
// Interrupt front end for the shared Timer0/1/2 flag registers. Arbitrates
// the enabled pending flags (TIFR & TIMSK) with the highest bit index winning,
// requests the CPU with the matching vector word address, and on acknowledge
// clears the serviced flag via the TIFR write port and pulses SREG I clear.
// On RETI it pulses SREG I set and holds off new requests for a few cycles.
//
// Ports
//   sysClock           system clock, rising edge
//   rst_n              asynchronous active-low reset
//   TIFR_input[7:0]    current TIFR value
//   TIMSK_input[7:0]   current TIMSK value
//   global_enable      SREG I bit
//   irq_ack            CPU loaded irq_vector into PC (1-cycle pulse)
//   reti               CPU executed RETI (1-cycle pulse)
//   irq_request        interrupt request to the CPU
//   irq_vector         word address of the vector to execute
//   TIFR_data[7:0]     TIFR write value with the serviced bit cleared
//   TIFR_write_enable  1-cycle TIFR write strobe
//   I_clear            1-cycle pulse: clear SREG I
//   I_set              1-cycle pulse: set SREG I
//   in_service         handler executing
// -----------------------------------------------------------------------------
module timer_interrupt_controller #(
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned VECTOR_BASE    = 0,
    parameter int unsigned HOLDOFF_CYCLES = 1
) (
    input  logic                  sysClock,
    input  logic                  rst_n,
    input  logic [7:0]            TIFR_input,
    input  logic [7:0]            TIMSK_input,
    input  logic                  global_enable,
    input  logic                  irq_ack,
    input  logic                  reti,
    output logic                  irq_request,
    output logic [ADDR_WIDTH-1:0] irq_vector,
    output logic [7:0]            TIFR_data,
    output logic                  TIFR_write_enable,
    output logic                  I_clear,
    output logic                  I_set,
    output logic                  in_service
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_SERVICE
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            holdoff_q, holdoff_d;
    logic [2:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] vector_q, vector_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [7:0]            data_q, data_d;
    logic                  clr_q, clr_d;
    logic                  set_q, set_d;
    logic                  ins_q, ins_d;

    logic [7:0]            pending;
    logic [2:0]            win_idx;
    logic [ADDR_WIDTH-1:0] win_vector;

    assign pending = TIFR_input & TIMSK_input;

    // Ascending scan: the last set bit seen is the highest index, which has
    // the highest priority (OCF2 at bit 7 down to TOV0 at bit 0).
    always_comb begin
        win_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    // Bit 7 maps to offset 0x008, each lower bit is one 2-word slot further.
    assign win_vector = ADDR_WIDTH'(VECTOR_BASE + 32'd8 + 32'd2 * (32'd7 - 32'(win_idx)));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        holdoff_d = holdoff_q;
        idx_d     = idx_q;
        vector_d  = vector_q;
        req_d     = req_q;
        ins_d     = ins_q;
        // Strobes and write data default low so they last exactly one cycle.
        we_d      = 1'b0;
        data_d    = 8'd0;
        clr_d     = 1'b0;
        set_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (holdoff_q != 4'd0) begin
                    holdoff_d = holdoff_q - 4'd1;
                end else if (global_enable && (pending != 8'd0)) begin
                    idx_d    = win_idx;
                    vector_d = win_vector;
                    req_d    = 1'b1;
                    state_d  = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                // Acknowledge takes precedence over a withdraw in the same cycle.
                if (irq_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b1;
                    data_d  = TIFR_input & ~(8'd1 << idx_q);
                    clr_d   = 1'b1;
                    ins_d   = 1'b1;
                    state_d = ST_SERVICE;
                end else if (!pending[idx_q] || !global_enable) begin
                    req_d     = 1'b0;
                    holdoff_d = 4'd0;
                    state_d   = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (reti) begin
                    set_d     = 1'b1;
                    ins_d     = 1'b0;
                    holdoff_d = 4'(HOLDOFF_CYCLES);
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            holdoff_q <= 4'd0;
            idx_q     <= 3'd0;
            vector_q  <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            data_q    <= 8'd0;
            clr_q     <= 1'b0;
            set_q     <= 1'b0;
            ins_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            holdoff_q <= holdoff_d;
            idx_q     <= idx_d;
            vector_q  <= vector_d;
            req_q     <= req_d;
            we_q      <= we_d;
            data_q    <= data_d;
            clr_q     <= clr_d;
            set_q     <= set_d;
            ins_q     <= ins_d;
        end
    end

    assign irq_request       = req_q;
    assign irq_vector        = vector_q;
    assign TIFR_data         = data_q;
    assign TIFR_write_enable = we_q;
    assign I_clear           = clr_q;
    assign I_set             = set_q;
    assign in_service        = ins_q;

endmodule

// File: tb/tb_timer_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_timer_interrupt_controller
//
// Directed scenarios with literal expectations, then a randomized run checked
// against a behavioural model. Two DUT copies share all inputs: one with the
// default vector base and one with base 0x1C00.
// Output snapshot packing: {req, vector[13:0], we, data[7:0], clr, set, ins}.
// -----------------------------------------------------------------------------
module tb_timer_interrupt_controller;

    localparam int HOLD = 1;

    logic        sysClock;
    logic        rst_n;
    logic [7:0]  TIFR_input, TIMSK_input;
    logic        global_enable, irq_ack, reti;

    logic        irq_request, TIFR_write_enable, I_clear, I_set, in_service;
    logic [13:0] irq_vector;
    logic [7:0]  TIFR_data;

    logic        b_irq_request, b_TIFR_write_enable, b_I_clear, b_I_set, b_in_service;
    logic [13:0] b_irq_vector;
    logic [7:0]  b_TIFR_data;

    int n_tests = 0;
    int n_fail  = 0;

    timer_interrupt_controller #(
        .ADDR_WIDTH(14), .VECTOR_BASE(0), .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .sysClock(sysClock), .rst_n(rst_n),
        .TIFR_input(TIFR_input), .TIMSK_input(TIMSK_input),
        .global_enable(global_enable), .irq_ack(irq_ack), .reti(reti),
        .irq_request(irq_request), .irq_vector(irq_vector),
        .TIFR_data(TIFR_data), .TIFR_write_enable(TIFR_write_enable),
        .I_clear(I_clear), .I_set(I_set), .in_service(in_service)
    );

    timer_interrupt_controller #(
        .ADDR_WIDTH(14), .VECTOR_BASE(32'h1C00), .HOLDOFF_CYCLES(HOLD)
    ) dut_b (
        .sysClock(sysClock), .rst_n(rst_n),
        .TIFR_input(TIFR_input), .TIMSK_input(TIMSK_input),
        .global_enable(global_enable), .irq_ack(irq_ack), .reti(reti),
        .irq_request(b_irq_request), .irq_vector(b_irq_vector),
        .TIFR_data(b_TIFR_data), .TIFR_write_enable(b_TIFR_write_enable),
        .I_clear(b_I_clear), .I_set(b_I_set), .in_service(b_in_service)
    );

    initial sysClock = 1'b0;
    always #5 sysClock = ~sysClock;

    function automatic logic [26:0] pk(input logic rq, input logic [13:0] vec, input logic we,
                                       input logic [7:0] dat, input logic clr, input logic st,
                                       input logic ins);
        return {rq, vec, we, dat, clr, st, ins};
    endfunction

    function automatic logic [26:0] obs_a();
        return pk(irq_request, irq_vector, TIFR_write_enable, TIFR_data, I_clear, I_set, in_service);
    endfunction

    function automatic logic [26:0] obs_b();
        return pk(b_irq_request, b_irq_vector, b_TIFR_write_enable, b_TIFR_data, b_I_clear,
                  b_I_set, b_in_service);
    endfunction

    // Advance one rising edge, then settle 1 time unit before looking/driving.
    task automatic tick();
        @(posedge sysClock);
        #1;
    endtask

    // From a pending request: acknowledge, clear flags, return, sit out holdoff.
    task automatic finish_service();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        TIFR_input = 8'h00; tick();
        reti = 1'b1; tick(); reti = 1'b0;
        tick(); tick();
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [26:0] exp;
        rst_n = 1'b0; TIFR_input = 8'hFF; TIMSK_input = 8'hFF;
        global_enable = 1'b1; irq_ack = 1'b0; reti = 1'b0;
        #3;
        exp = '0;
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL reset_async: got %h want %h", obs_a(), exp); end
        tick(); tick();
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL reset_held: got %h want %h", obs_a(), exp); end
        TIFR_input = 8'h00; TIMSK_input = 8'h00;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL reset_idle: got %h want %h", obs_a(), exp); end
    endtask

    task automatic test_single();
        logic [26:0] exp;
        TIMSK_input = 8'h01; TIFR_input = 8'h01; global_enable = 1'b1;
        tick();
        exp = pk(1, 14'h016, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL single_req: got %h want %h", obs_a(), exp); end
        tick();
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL single_hold: got %h want %h", obs_a(), exp); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; TIFR_input = 8'h00;
        exp = pk(0, 14'h016, 1, 8'h00, 1, 0, 1);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL single_ack: got %h want %h", obs_a(), exp); end
        tick();
        exp = pk(0, 14'h016, 0, 8'h00, 0, 0, 1);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL single_service: got %h want %h", obs_a(), exp); end
        reti = 1'b1; tick(); reti = 1'b0;
        exp = pk(0, 14'h016, 0, 8'h00, 0, 1, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL single_reti: got %h want %h", obs_a(), exp); end
        tick();
        exp = pk(0, 14'h016, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL single_pulse_end: got %h want %h", obs_a(), exp); end
    endtask

    task automatic test_priority_holdoff();
        logic [26:0] exp;
        TIMSK_input = 8'h03; TIFR_input = 8'h03;
        tick();
        exp = pk(1, 14'h014, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL prio_req: got %h want %h", obs_a(), exp); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; TIFR_input = 8'h01;
        exp = pk(0, 14'h014, 1, 8'h01, 1, 0, 1);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL prio_ack: got %h want %h", obs_a(), exp); end
        tick();
        reti = 1'b1; tick(); reti = 1'b0;
        exp = pk(0, 14'h014, 0, 8'h00, 0, 1, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL prio_reti: got %h want %h", obs_a(), exp); end
        tick();
        exp = pk(0, 14'h014, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL prio_holdoff: got %h want %h", obs_a(), exp); end
        tick();
        exp = pk(1, 14'h016, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL prio_after_holdoff: got %h want %h", obs_a(), exp); end
        finish_service();
    endtask

    task automatic test_latching();
        logic [26:0] exp;
        TIMSK_input = 8'h81; TIFR_input = 8'h01;
        tick();
        TIFR_input = 8'h81;
        tick();
        exp = pk(1, 14'h016, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL latch_hold: got %h want %h", obs_a(), exp); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        exp = pk(0, 14'h016, 1, 8'h80, 1, 0, 1);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL latch_ack: got %h want %h", obs_a(), exp); end
        TIFR_input = 8'h00; tick();
        reti = 1'b1; tick(); reti = 1'b0;
        tick(); tick();
    endtask

    task automatic test_mask_withdraw();
        logic [26:0] exp;
        TIFR_input = 8'h04; TIMSK_input = 8'h00; global_enable = 1'b1;
        tick(); tick();
        exp = pk(0, 14'h016, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL mask_timsk: got %h want %h", obs_a(), exp); end
        TIMSK_input = 8'h04; global_enable = 1'b0;
        tick(); tick();
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL mask_global: got %h want %h", obs_a(), exp); end
        global_enable = 1'b1; tick();
        exp = pk(1, 14'h012, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL mask_req: got %h want %h", obs_a(), exp); end
        TIMSK_input = 8'h00; tick();
        exp = pk(0, 14'h012, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL withdraw_mask: got %h want %h", obs_a(), exp); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL late_ack_ignored: got %h want %h", obs_a(), exp); end
        TIMSK_input = 8'h04; tick();
        global_enable = 1'b0; tick();
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL withdraw_global: got %h want %h", obs_a(), exp); end
        global_enable = 1'b1; tick();
        exp = pk(1, 14'h012, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL withdraw_no_holdoff: got %h want %h", obs_a(), exp); end
        finish_service();
        TIMSK_input = 8'h00;
    endtask

    task automatic test_base_offset();
        logic [26:0] exp;
        TIFR_input = 8'h10; TIMSK_input = 8'h10; global_enable = 1'b1;
        tick();
        exp = pk(1, 14'h1C0E, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_b() !== exp) begin n_fail++; $display("FAIL base_vector: got %h want %h", obs_b(), exp); end
        exp = pk(1, 14'h00E, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL base_zero_vector: got %h want %h", obs_a(), exp); end
    endtask

    // Entered with a request outstanding and TIFR = TIMSK = 0x10.
    task automatic test_reset_mid();
        logic [26:0] exp;
        #3 rst_n = 1'b0;
        #1;
        exp = '0;
        n_tests++;
        if (obs_a() !== exp || obs_b() !== exp) begin
            n_fail++; $display("FAIL reset_in_request: got %h/%h want %h", obs_a(), obs_b(), exp);
        end
        tick(); rst_n = 1'b1; tick();
        exp = pk(1, 14'h00E, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL reset_rel_req1: got %h want %h", obs_a(), exp); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        exp = pk(0, 14'h00E, 1, 8'h00, 1, 0, 1);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL reset_pre_ack: got %h want %h", obs_a(), exp); end
        tick();
        #3 rst_n = 1'b0;
        #1;
        exp = '0;
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL reset_in_service: got %h want %h", obs_a(), exp); end
        tick(); rst_n = 1'b1; tick();
        exp = pk(1, 14'h00E, 0, 8'h00, 0, 0, 0);
        n_tests++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL reset_rel_req2: got %h want %h", obs_a(), exp); end
        finish_service();
        TIMSK_input = 8'h00;
    endtask

    // ----------------------------------------------------- reference model
    // The model tracks only what the interface exposes: an outstanding
    // request, a running handler, the remaining quiet cycles after a return.
    int          vec_tab [8] = '{32'h016, 32'h014, 32'h012, 32'h010, 32'h00E, 32'h00C, 32'h00A, 32'h008};
    logic        e_req, e_we, e_clr, e_set, e_ins;
    logic [7:0]  e_data;
    logic [13:0] m_vec, m_vec_b;
    int          m_idx, m_hold;

    task automatic model_reset();
        e_req = 0; e_we = 0; e_clr = 0; e_set = 0; e_ins = 0; e_data = 8'h00;
        m_vec = 14'h0; m_vec_b = 14'h0; m_idx = 0; m_hold = 0;
    endtask

    // Apply one clock edge with the inputs currently on the pins.
    task automatic model_edge();
        logic [7:0] pend;
        pend = TIFR_input & TIMSK_input;
        e_we = 0; e_data = 8'h00; e_clr = 0; e_set = 0;
        if (e_req) begin
            if (irq_ack) begin
                e_req = 0; e_we = 1; e_clr = 1; e_ins = 1;
                e_data = TIFR_input & ~(8'd1 << m_idx);
            end else if (!pend[m_idx] || !global_enable) begin
                e_req = 0;
            end
        end else if (e_ins) begin
            if (reti) begin
                e_set = 1; e_ins = 0; m_hold = HOLD;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (global_enable && pend != 8'h00) begin
            m_idx   = $clog2(int'(pend) + 1) - 1;
            m_vec   = 14'(vec_tab[m_idx]);
            m_vec_b = 14'(32'h1C00 + vec_tab[m_idx]);
            e_req   = 1;
        end
    endtask

    task automatic test_random();
        logic [26:0] exp;
        rst_n = 1'b0; tick();
        model_reset();
        TIFR_input = 8'($urandom); TIMSK_input = 8'($urandom);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 4) == 0) TIFR_input = 8'($urandom);
            if ($urandom_range(0, 9) == 0) TIMSK_input = 8'($urandom);
            global_enable = ($urandom_range(0, 9) != 0);
            irq_ack       = ($urandom_range(0, 2) == 0);
            reti          = ($urandom_range(0, 2) == 0);
            tick();
            model_edge();
            exp = pk(e_req, m_vec, e_we, e_data, e_clr, e_set, e_ins);
            n_tests++;
            if (obs_a() !== exp || b_irq_vector !== m_vec_b) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h (base vec %h) want %h (base vec %h)",
                         cyc, obs_a(), b_irq_vector, exp, m_vec_b);
            end
        end
        irq_ack = 1'b0; reti = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority_holdoff();
        test_latching();
        test_mask_withdraw();
        test_base_offset();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
